// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start bit, DATA_W data bits LSB first, optional
// even/odd parity and one or two stop bits, one word per valid/ready handshake.
module uart_tx_cfg #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115_200,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              tx_ready,
    input  logic [1:0]        cfg_parity,
    input  logic              cfg_stop2,
    output logic              busy,
    output logic              tx
);

    localparam int CPB   = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB) + 1;
    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    generate
        if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
            $error("uart_tx_cfg: DATA_W must be in 5..9");
        end
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  clk_cnt_reg;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic [DATA_W-1:0] shift_reg;
    logic              par_en_reg;
    logic              par_bit_reg;
    logic              stop2_reg;

    wire bit_done = (clk_cnt_reg == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            stop2_reg   <= 1'b0;
            tx          <= 1'b1;
            tx_ready    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx          <= 1'b1;
                    clk_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    if (tx_ready && din_valid) begin
                        // Parity is resolved at capture so later din/cfg changes cannot leak in.
                        shift_reg   <= din;
                        par_en_reg  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                        par_bit_reg <= (cfg_parity == 2'b10) ? ~^din : ^din;
                        stop2_reg   <= cfg_stop2;
                        tx          <= 1'b0;
                        tx_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state_reg   <= START;
                    end else begin
                        tx_ready    <= 1'b1;
                        busy        <= 1'b0;
                    end
                end

                START: begin
                    if (bit_done) begin
                        clk_cnt_reg <= '0;
                        tx          <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state_reg   <= DATA;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        clk_cnt_reg <= '0;
                        if (bit_idx_reg == IDX_LAST) begin
                            bit_idx_reg <= '0;
                            if (par_en_reg) begin
                                tx        <= par_bit_reg;
                                state_reg <= PARITY;
                            end else begin
                                tx        <= 1'b1;
                                state_reg <= STOP;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            tx          <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                PARITY: begin
                    if (bit_done) begin
                        clk_cnt_reg <= '0;
                        tx          <= 1'b1;
                        state_reg   <= STOP;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        clk_cnt_reg <= '0;
                        // bit_idx_reg doubles as the stop-bit counter here.
                        if (stop2_reg && bit_idx_reg == '0) begin
                            bit_idx_reg <= IDX_W'(1);
                        end else begin
                            bit_idx_reg <= '0;
                            tx          <= 1'b1;
                            tx_ready    <= 1'b1;
                            busy        <= 1'b0;
                            state_reg   <= IDLE;
                        end
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    clk_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    tx          <= 1'b1;
                    tx_ready    <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
